// File: rtl/fpu_addsub_arbiter_if.sv
// Request/response bundle between the requesters, the shared FPU add/sub
// unit and the arbiter that schedules them.
interface fpu_addsub_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
);

  // Requester side: per-lane operation offer and one-hot grant back
  logic [NUM_REQ-1:0]    i_req_valid;
  logic [NUM_REQ-1:0]    i_req_op;
  logic [32*NUM_REQ-1:0] i_req_a;
  logic [32*NUM_REQ-1:0] i_req_b;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic                  i_hold;

  // FPU side: operands out, sum/difference back
  logic                  o_fpu_add_sub;
  logic [31:0]           o_fpu_a;
  logic [31:0]           o_fpu_b;
  logic [31:0]           i_fpu_s;

  // Result return and status
  logic [NUM_REQ-1:0]    o_rsp_valid;
  logic [31:0]           o_rsp_data;
  logic                  o_busy;
  logic [CNT_W-1:0]      o_issue_cnt;

  // Arbiter view
  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b, i_hold, i_fpu_s,
    output o_req_ready, o_fpu_add_sub, o_fpu_a, o_fpu_b,
           o_rsp_valid, o_rsp_data, o_busy, o_issue_cnt
  );

  // Requester/FPU environment view
  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b, i_hold, i_fpu_s,
    input  o_req_ready, o_fpu_add_sub, o_fpu_a, o_fpu_b,
           o_rsp_valid, o_rsp_data, o_busy, o_issue_cnt
  );

endinterface

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin scheduler sharing one pipelined FPU add/sub unit between
// NUM_REQ requesters. At most one operation is issued per cycle; a tag
// pipeline as deep as the FPU latency remembers who issued each operation
// so the result can be strobed back to its originator.
module fpu_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  fpu_addsub_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  // Unpacked per-requester operand views
  logic [31:0] req_a_arr [NUM_REQ];
  logic [31:0] req_b_arr [NUM_REQ];

  // Arbitration state and decisions
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   ptr_next;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand_sel;
  logic               grant_found;
  logic               issue_en;
  logic [NUM_REQ-1:0] grant_onehot;
  int                 cand_idx;

  // In-flight tracking
  logic [FPU_LAT-1:0] tag_vld_reg;
  logic [IDX_W-1:0]   tag_id_reg [FPU_LAT];
  logic [CNT_W-1:0]   issue_cnt_reg;
  logic [NUM_REQ-1:0] rsp_onehot;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi] = bus.i_req_a[32*gi +: 32];
      assign req_b_arr[gi] = bus.i_req_b[32*gi +: 32];
    end
  endgenerate

  // Rotating priority search: first valid requester at or after the pointer
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = 0;
    cand_sel    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = int'(ptr_reg) + k;
      if (cand_idx >= NUM_REQ) begin
        cand_idx = cand_idx - NUM_REQ;
      end
      cand_sel = cand_idx[IDX_W-1:0];
      if (!grant_found && bus.i_req_valid[cand_sel]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sel;
      end
    end
  end

  // No grant is offered while in reset or stalled by hold
  assign issue_en = i_rst_n & ~bus.i_hold & grant_found;

  // One-hot grant and wrap-around successor of the granted index
  always_comb begin
    grant_onehot = '0;
    if (issue_en) begin
      grant_onehot[grant_idx] = 1'b1;
    end
    ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
  end

  assign bus.o_req_ready = grant_onehot;

  // Operand mux to the FPU; idle slots present zeros
  always_comb begin
    bus.o_fpu_a       = '0;
    bus.o_fpu_b       = '0;
    bus.o_fpu_add_sub = 1'b0;
    if (issue_en) begin
      bus.o_fpu_a       = req_a_arr[grant_idx];
      bus.o_fpu_b       = req_b_arr[grant_idx];
      bus.o_fpu_add_sub = bus.i_req_op[grant_idx];
    end
  end

  // Pointer advances past the winner only when an operation is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_reg <= '0;
    end else if (issue_en) begin
      ptr_reg <= ptr_next;
    end
  end

  // Count of accepted operations, free-running wrap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      issue_cnt_reg <= '0;
    end else if (issue_en) begin
      issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
    end
  end

  // Tag pipeline mirrors the FPU latency and never stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < FPU_LAT; s++) begin
        tag_vld_reg[s] <= 1'b0;
        tag_id_reg[s]  <= '0;
      end
    end else begin
      tag_vld_reg[0] <= issue_en;
      tag_id_reg[0]  <= grant_idx;
      for (int s = 1; s < FPU_LAT; s++) begin
        tag_vld_reg[s] <= tag_vld_reg[s-1];
        tag_id_reg[s]  <= tag_id_reg[s-1];
      end
    end
  end

  // Route the FPU result to the requester named by the oldest tag
  always_comb begin
    rsp_onehot = '0;
    if (tag_vld_reg[FPU_LAT-1]) begin
      rsp_onehot[tag_id_reg[FPU_LAT-1]] = 1'b1;
    end
  end

  assign bus.o_rsp_valid = rsp_onehot;
  // Result data is forced to zero in slots that carry no tagged operation
  assign bus.o_rsp_data  = tag_vld_reg[FPU_LAT-1] ? bus.i_fpu_s : 32'h0;
  assign bus.o_busy      = |tag_vld_reg;
  assign bus.o_issue_cnt = issue_cnt_reg;

endmodule

// File: doc/fpu_addsub_arbiter.md
Name: fpu_addsub_arbiter

Overview:
- Round-robin arbiter/scheduler that shares one pipelined FPU_top add/sub unit (NUM_OP=1) between NUM_REQ requesters, e.g. the butterfly lanes of the 8-point FFT.
- Accepts at most one operation per cycle over per-requester valid/ready handshakes.
- Drives the FPU operand ports and tracks the requester ID of each in-flight operation through a tag pipeline matched to the FPU latency.
- Returns each result to its originator with a one-hot response strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FPU_LAT, 2, cycles from operands presented on o_fpu_* to result valid on i_fpu_s (FPU_top input regs + output reg).
- CNT_W, 16, width of the issued-operation counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  NUM_REQ  per-requester operation valid.
- i_req_op  in  NUM_REQ  per-requester op select: 0 = a+b, 1 = a-b.
- i_req_a  in  32*NUM_REQ  operand A of requester i at bits [32i+31:32i], IEEE-754 single.
- i_req_b  in  32*NUM_REQ  operand B, same packing.
- o_req_ready  out  NUM_REQ  one-hot grant; handshake occurs when valid&ready.
- i_hold  in  1  issue stall; no grant while high, in-flight ops still complete.
- o_fpu_add_sub  out  1  to FPU_top i_add_sub.
- o_fpu_a  out  32  to FPU_top i_32_a.
- o_fpu_b  out  32  to FPU_top i_32_b.
- i_fpu_s  in  32  from FPU_top o_32_s.
- o_rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle.
- o_rsp_data  out  32  result, valid when any o_rsp_valid bit is set.
- o_busy  out  1  any operation in flight.
- o_issue_cnt  out  CNT_W  count of accepted operations.

Behaviour:
- Reset (async, i_rst_n=0) clears:
  - RR pointer to 0 and all tag pipeline stages to invalid;
  - o_issue_cnt to 0, o_busy to 0, o_rsp_valid to 0.
  - o_req_ready is 0 during reset.
- Arbitration is combinational within the cycle.
  - Search starts at pointer p: order p, p+1, …, NUM_REQ-1, 0, …, p-1.
  - First requester with i_req_valid=1 is granted: o_req_ready = onehot(g).
  - If i_hold=1 or no valid request: o_req_ready = 0 and the pointer is unchanged.
- o_req_ready may depend on i_req_valid. Requesters must not make valid depend on ready.
- On a grant to g at cycle t:
  - pointer <= (g+1) mod NUM_REQ;
  - o_issue_cnt <= o_issue_cnt+1, wrapping at 2^CNT_W;
  - tag stage 0 <= {valid=1, id=g}.
- o_fpu_a/b/add_sub are a combinational mux of requester g's fields when a grant is made. Otherwise they are 0, and the FPU result for an idle slot is ignored.
- Tag pipeline: FPU_LAT stages, shifting every cycle; there is no stall, and i_hold does not freeze it.
- Result delivery:
  - An op accepted at cycle t produces o_rsp_valid[g]=1 in cycle t+FPU_LAT.
  - o_rsp_data = i_fpu_s, combinational pass-through, that same cycle.
  - o_rsp_valid = 0 when the last tag stage is invalid.
  - Requesters must accept responses unconditionally; there is no response backpressure.
- Throughput: one op per cycle sustained. Back-to-back grants to different requesters produce back-to-back responses in issue order.
- o_busy = OR of all tag-stage valid bits, registered view; high in cycles t+1..t+FPU_LAT after a grant at t.
- A requester holding valid with changing data is a protocol violation. Fields are sampled only in the handshake cycle.
- Reset mid-operation discards in-flight tags; no response is issued for them even though the FPU output may change.
- Requests arriving while i_hold=1 are not lost; they are granted in the first cycle i_hold=0.

Test Plan:
- Single op: req0 a=0x3F800000 (1.0), b=0x40000000 (2.0), op=0 at t=5.
  - Expected: o_req_ready=0001 at t=5; o_rsp_valid=0001 with o_rsp_data=0x40400000 (3.0) at t=7.
  - Expected: o_busy high t=6..7; o_issue_cnt=1.
- Subtract: req2 a=0x40400000, b=0x3F800000, op=1.
  - Expected: response 0x40000000 on o_rsp_valid=0100 exactly FPU_LAT cycles later.
- Round-robin fairness: all 4 requesters valid continuously for 8 cycles from reset.
  - Expected grant order: 0,1,2,3,0,1,2,3; responses in the same order; o_issue_cnt=8.
- Hold: all valid, i_hold=1 for 3 cycles, then 0.
  - Expected: no grants and pointer unchanged during hold; in-flight ops still return; first grant after release goes to the pointer value held.
- Async reset mid-flight: grant at t, i_rst_n low at t+1.
  - Expected: all outputs 0 immediately; no o_rsp_valid at t+2; pointer 0 after release.
- Counter wrap: CNT_W=4, 17 accepted ops.
  - Expected: o_issue_cnt=1.
